// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define SEQDIV_DIV0_EN for the early divide-by-zero exit.
module seq_restoring_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SEQDIV_DIV0_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic             bo;
  logic             accept;

  always_comb begin
    s = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    // Extra top bit of the wide difference is the borrow-out.
    {bo, t} = {1'b0, s} - {2'b00, b_q};
    accept = start && (state_q == S_IDLE || state_q == S_DONE);

    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef SEQDIV_DIV0_EN
    dbz_d   = dbz_q;
`endif

    if (accept) begin
      state_d = S_RUN;
      a_d     = '0;
      q_d     = dividend;
      b_d     = divisor;
      cnt_d   = '0;
`ifdef SEQDIV_DIV0_EN
      if (divisor == '0) begin
        state_d = S_DONE;
        quo_d   = '1;
        rem_d   = dividend;
        dbz_d   = 1'b1;
      end
`endif
    end else if (state_q == S_RUN) begin
      a_d   = bo ? s : t;
      q_d   = {q_q[WIDTH-2:0], ~bo};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = S_DONE;
        quo_d   = q_d;
        rem_d   = a_d[WIDTH-1:0];
`ifdef SEQDIV_DIV0_EN
        dbz_d   = 1'b0;
`endif
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef SEQDIV_DIV0_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SEQDIV_DIV0_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef SEQDIV_DIV0_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
